// File: rtl/adc_qdr_cal_pkg.sv
// rtl/adc_qdr_cal_pkg.sv - shared types and constants for the QDR ADC phase calibrator
package adc_qdr_cal_pkg;

   // Calibration sequencer states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_MEASURE,
      ST_DECIDE,
      ST_LOCKED,
      ST_FAIL
   } cal_state_t;

   localparam int NUM_CAND = 4;

   // Candidate (even, odd) pairings of the four capture streams
   localparam logic [1:0] CAND_R0F0   = 2'd0;  // (rise_0, fall_0)
   localparam logic [1:0] CAND_R90F90 = 2'd1;  // (rise_90, fall_90)
   localparam logic [1:0] CAND_F0R0   = 2'd2;  // (fall_0 delayed, rise_0)
   localparam logic [1:0] CAND_F90R90 = 2'd3;  // (fall_90 delayed, rise_90)

endpackage

// File: rtl/adc_qdr_pair_mux.sv
// rtl/adc_qdr_pair_mux.sv - delayed-fall registers and registered 4:1 even/odd pair mux
module adc_qdr_pair_mux
   import adc_qdr_cal_pkg::*;
#(
   parameter int width = 8
) (
   input  logic             clk_0,
   input  logic             rst_n,
   input  logic [1:0]       phase_sel,
   input  logic [width-1:0] data_rise_0,
   input  logic [width-1:0] data_fall_0,
   input  logic [width-1:0] data_rise_90,
   input  logic [width-1:0] data_fall_90,
   output logic [width-1:0] data_even,
   output logic [width-1:0] data_odd
);

   logic [width-1:0] fall_0_d;
   logic [width-1:0] fall_90_d;
   logic [width-1:0] pair_even;
   logic [width-1:0] pair_odd;

   // Fall samples delayed by one cycle so a fall can lead the next rise
   always_ff @(posedge clk_0 or negedge rst_n) begin
      if (!rst_n) begin
         fall_0_d  <= '0;
         fall_90_d <= '0;
      end else begin
         fall_0_d  <= data_fall_0;
         fall_90_d <= data_fall_90;
      end
   end

   // Form the candidate pair selected by phase_sel
   always_comb begin
      pair_even = data_rise_0;
      pair_odd  = data_fall_0;
      case (phase_sel)
         CAND_R0F0: begin
            pair_even = data_rise_0;
            pair_odd  = data_fall_0;
         end
         CAND_R90F90: begin
            pair_even = data_rise_90;
            pair_odd  = data_fall_90;
         end
         CAND_F0R0: begin
            pair_even = fall_0_d;
            pair_odd  = data_rise_0;
         end
         CAND_F90R90: begin
            pair_even = fall_90_d;
            pair_odd  = data_rise_90;
         end
         default: begin
            pair_even = data_rise_0;
            pair_odd  = data_fall_0;
         end
      endcase
   end

   // Register the selected pair; this is both the downstream output and the comparator input
   always_ff @(posedge clk_0 or negedge rst_n) begin
      if (!rst_n) begin
         data_even <= '0;
         data_odd  <= '0;
      end else begin
         data_even <= pair_even;
         data_odd  <= pair_odd;
      end
   end

endmodule

// File: rtl/adc_qdr_phase_cal.sv
// rtl/adc_qdr_phase_cal.sv - training-pattern calibrator and lane selector for the QDR ADC capture path
module adc_qdr_phase_cal
   import adc_qdr_cal_pkg::*;
#(
   parameter int width      = 8,
   parameter int WINDOW     = 1024,
   parameter int SETTLE     = 4,
   parameter int CNT_W      = 12,
   parameter int ERR_THRESH = 0
) (
   input  logic             clk_0,
   input  logic             rst_n,
   input  logic             cal_start,
   input  logic [width-1:0] data_rise_0,
   input  logic [width-1:0] data_fall_0,
   input  logic [width-1:0] data_rise_90,
   input  logic [width-1:0] data_fall_90,
   input  logic [width-1:0] pattern_even,
   input  logic [width-1:0] pattern_odd,
   output logic [width-1:0] data_even,
   output logic [width-1:0] data_odd,
   output logic             data_valid,
   output logic [1:0]       phase_sel,
   output logic [CNT_W-1:0] best_err,
   output logic             cal_busy,
   output logic             cal_done,
   output logic             cal_fail
);

   // One cycle counter shared by the settle and measure phases
   localparam int CYC_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
   localparam int CYC_W   = $clog2(CYC_MAX);
   localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE - 1);
   localparam logic [CYC_W-1:0] WINDOW_LAST = CYC_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] THRESH      = CNT_W'(ERR_THRESH);
   localparam logic [1:0]       LAST_CAND   = 2'(NUM_CAND - 1);

   cal_state_t       state;
   cal_state_t       state_nxt;
   logic [CYC_W-1:0] cyc_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] best_cnt;
   logic [1:0]       best_idx;
   logic             cmp_err;
   logic             cand_better;
   logic             last_cand;
   logic [CNT_W-1:0] final_cnt;
   logic [1:0]       final_idx;

   adc_qdr_pair_mux #(
      .width (width)
   ) u_pair_mux (
      .clk_0        (clk_0),
      .rst_n        (rst_n),
      .phase_sel    (phase_sel),
      .data_rise_0  (data_rise_0),
      .data_fall_0  (data_fall_0),
      .data_rise_90 (data_rise_90),
      .data_fall_90 (data_fall_90),
      .data_even    (data_even),
      .data_odd     (data_odd)
   );

   // Compare on the registered mux output; best-so-far includes the candidate just measured
   always_comb begin
      cmp_err     = (data_even != pattern_even) || (data_odd != pattern_odd);
      cand_better = (err_cnt < best_cnt);
      last_cand   = (phase_sel == LAST_CAND);
      final_cnt   = cand_better ? err_cnt : best_cnt;
      final_idx   = cand_better ? phase_sel : best_idx;
   end

   // State register
   always_ff @(posedge clk_0 or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; cal_start only matters outside the busy states
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_LOCKED, ST_FAIL: begin
            if (cal_start) state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cyc_cnt == SETTLE_LAST) state_nxt = ST_MEASURE;
         end
         ST_MEASURE: begin
            if (cyc_cnt == WINDOW_LAST) state_nxt = ST_DECIDE;
         end
         ST_DECIDE: begin
            if (!last_cand)              state_nxt = ST_SETTLE;
            else if (final_cnt <= THRESH) state_nxt = ST_LOCKED;
            else                         state_nxt = ST_FAIL;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Counters, best-candidate tracking, candidate stepping and the done pulse
   always_ff @(posedge clk_0 or negedge rst_n) begin
      if (!rst_n) begin
         cyc_cnt   <= '0;
         err_cnt   <= '0;
         best_cnt  <= '1;
         best_idx  <= CAND_R0F0;
         phase_sel <= CAND_R0F0;
         best_err  <= '0;
         cal_done  <= 1'b0;
      end else begin
         cal_done <= 1'b0;
         case (state)
            ST_IDLE, ST_LOCKED, ST_FAIL: begin
               if (cal_start) begin
                  cyc_cnt   <= '0;
                  best_cnt  <= '1;
                  best_idx  <= CAND_R0F0;
                  phase_sel <= CAND_R0F0;
               end
            end
            ST_SETTLE: begin
               if (cyc_cnt == SETTLE_LAST) begin
                  cyc_cnt <= '0;
                  err_cnt <= '0;
               end else begin
                  cyc_cnt <= cyc_cnt + 1'b1;
               end
            end
            ST_MEASURE: begin
               cyc_cnt <= cyc_cnt + 1'b1;
               if (cmp_err && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + 1'b1;
            end
            ST_DECIDE: begin
               cyc_cnt  <= '0;
               best_cnt <= final_cnt;
               best_idx <= final_idx;
               if (!last_cand) begin
                  phase_sel <= phase_sel + 2'd1;
               end else begin
                  phase_sel <= final_idx;
                  best_err  <= final_cnt;
                  cal_done  <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Status outputs decoded from the state register
   always_comb begin
      data_valid = (state == ST_LOCKED);
      cal_fail   = (state == ST_FAIL);
      cal_busy   = (state == ST_SETTLE) || (state == ST_MEASURE) || (state == ST_DECIDE);
   end

endmodule

// File: tb/tb_adc_qdr_phase_cal.sv
// tb/tb_adc_qdr_phase_cal.sv - self-checking bench for adc_qdr_phase_cal
module tb_adc_qdr_phase_cal;

   localparam int W        = 8;
   localparam int WINDOW   = 1024;
   localparam int SETTLE   = 4;
   localparam int CNT_W    = 12;
   localparam int CAL_CYC  = 4 * (SETTLE + WINDOW) + 4;
   localparam int SLOT     = SETTLE + WINDOW + 1;
   localparam int HMAX     = 65536;
   localparam logic [7:0] PE = 8'hA5;
   localparam logic [7:0] PO = 8'h5A;

   logic             clk_0 = 1'b0;
   logic             rst_n = 1'b0;
   logic             cal_start = 1'b0;
   logic [W-1:0]     data_rise_0 = '0;
   logic [W-1:0]     data_fall_0 = '0;
   logic [W-1:0]     data_rise_90 = '0;
   logic [W-1:0]     data_fall_90 = '0;
   logic [W-1:0]     pattern_even = PE;
   logic [W-1:0]     pattern_odd = PO;
   logic [W-1:0]     data_even;
   logic [W-1:0]     data_odd;
   logic             data_valid;
   logic [1:0]       phase_sel;
   logic [CNT_W-1:0] best_err;
   logic             cal_busy;
   logic             cal_done;
   logic             cal_fail;

   adc_qdr_phase_cal #(
      .width (W), .WINDOW (WINDOW), .SETTLE (SETTLE), .CNT_W (CNT_W), .ERR_THRESH (0)
   ) dut (
      .clk_0        (clk_0),
      .rst_n        (rst_n),
      .cal_start    (cal_start),
      .data_rise_0  (data_rise_0),
      .data_fall_0  (data_fall_0),
      .data_rise_90 (data_rise_90),
      .data_fall_90 (data_fall_90),
      .pattern_even (pattern_even),
      .pattern_odd  (pattern_odd),
      .data_even    (data_even),
      .data_odd     (data_odd),
      .data_valid   (data_valid),
      .phase_sel    (phase_sel),
      .best_err     (best_err),
      .cal_busy     (cal_busy),
      .cal_done     (cal_done),
      .cal_fail     (cal_fail)
   );

   always #5 clk_0 = ~clk_0;

   int edge_n = 0;
   always @(posedge clk_0) edge_n <= edge_n + 1;

   // Input history indexed by the posedge that samples it: 0=rise_0 1=fall_0 2=rise_90 3=fall_90
   logic [7:0] h_r0  [HMAX];
   logic [7:0] h_f0  [HMAX];
   logic [7:0] h_r90 [HMAX];
   logic [7:0] h_f90 [HMAX];

   // Per-channel stimulus: constant value or random, plus optional single-bit corruption
   logic [7:0] c_val [4];
   bit         c_rnd [4];
   int         corrupt_div = 0;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      logic [7:0] v [4];
      int n;
      for (int i = 0; i < 4; i++) begin
         v[i] = c_rnd[i] ? 8'($urandom) : c_val[i];
         if (corrupt_div > 0 && $urandom_range(0, corrupt_div - 1) == 0) v[i] = v[i] ^ 8'h01;
      end
      data_rise_0  = v[0];
      data_fall_0  = v[1];
      data_rise_90 = v[2];
      data_fall_90 = v[3];
      n = edge_n + 1;
      h_r0[n]  = v[0];
      h_f0[n]  = v[1];
      h_r90[n] = v[2];
      h_f90[n] = v[3];
   endtask

   task automatic tick();
      @(negedge clk_0);
      drive();
   endtask

   // Configure stimulus so candidate k sees the training pattern; other channels random
   task automatic setup_match(input int k);
      for (int i = 0; i < 4; i++) begin
         c_rnd[i] = 1'b1;
         c_val[i] = 8'h00;
      end
      case (k)
         0: begin c_val[0] = PE; c_val[1] = PO; c_rnd[0] = 0; c_rnd[1] = 0; end
         1: begin c_val[2] = PE; c_val[3] = PO; c_rnd[2] = 0; c_rnd[3] = 0; end
         2: begin c_val[1] = PE; c_val[0] = PO; c_rnd[0] = 0; c_rnd[1] = 0; end
         default: begin c_val[3] = PE; c_val[2] = PO; c_rnd[2] = 0; c_rnd[3] = 0; end
      endcase
   endtask

   // Candidate pair {even, odd} as seen on the output after posedge p
   function automatic logic [15:0] pair_at(input int k, input int p);
      case (k)
         0:       return {h_r0[p], h_f0[p]};
         1:       return {h_r90[p], h_f90[p]};
         2:       return {h_f0[p-1], h_r0[p]};
         default: return {h_f90[p-1], h_r90[p]};
      endcase
   endfunction

   // Reference: count mismatches of each candidate over its measure window, pick strict minimum
   task automatic model_cal(input int s, output int b_idx, output int b_cnt);
      int best;
      int e;
      int first;
      best  = (1 << CNT_W) - 1;
      b_idx = 0;
      for (int k = 0; k < 4; k++) begin
         e = 0;
         first = s + k * SLOT + SETTLE;
         for (int p = first; p < first + WINDOW; p++)
            if (pair_at(k, p) != {PE, PO}) e++;
         if (e > (1 << CNT_W) - 1) e = (1 << CNT_W) - 1;
         if (e < best) begin
            best  = e;
            b_idx = k;
         end
      end
      b_cnt = best;
   endtask

   task automatic run_cal(input string tag, input bit poke_busy, output int b_idx);
      int s;
      int done_at;
      int pulses;
      int b_cnt;
      tick();
      cal_start = 1'b1;
      s = edge_n + 1;
      tick();
      cal_start = 1'b0;
      check({tag, " busy after start"}, cal_busy, 1);
      check({tag, " valid drops at start"}, data_valid, 0);
      done_at = -1;
      pulses  = 0;
      for (int i = 0; i < CAL_CYC + 20; i++) begin
         tick();
         if (cal_done) begin
            pulses++;
            if (done_at < 0) done_at = edge_n;
         end
         cal_start = (poke_busy && cal_busy && $urandom_range(0, 63) == 0);
         if (done_at >= 0 && edge_n >= done_at + 3) break;
      end
      cal_start = 1'b0;
      model_cal(s, b_idx, b_cnt);
      check({tag, " done latency"}, done_at - s, CAL_CYC);
      check({tag, " done pulses"}, pulses, 1);
      check({tag, " phase_sel"}, phase_sel, b_idx);
      check({tag, " best_err"}, best_err, b_cnt);
      check({tag, " data_valid"}, data_valid, (b_cnt == 0));
      check({tag, " cal_fail"}, cal_fail, (b_cnt != 0));
      check({tag, " cal_busy idle"}, cal_busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      int s;
      int target;
      int pulses;

      for (int i = 0; i < HMAX; i++) begin
         h_r0[i] = 0; h_f0[i] = 0; h_r90[i] = 0; h_f90[i] = 0;
      end
      setup_match(1);
      rst_n = 1'b0;
      repeat (3) tick();
      check("reset outputs",
            {data_even, data_odd, data_valid, phase_sel, best_err, cal_busy, cal_done, cal_fail}, 0);
      rst_n = 1'b1;
      repeat (3) tick();
      check("idle busy", cal_busy, 0);
      check("idle valid", data_valid, 0);

      // Candidate 1 matches; busy-time cal_start pulses must not change anything
      setup_match(1);
      run_cal("t1", 1'b1, idx);
      check("t1 expect cand1", phase_sel, 1);
      check("t1 data_even", data_even, PE);
      check("t1 data_odd", data_odd, PO);

      // Candidate 2 matches; after lock outputs follow delayed fall_0 / current rise_0
      setup_match(2);
      run_cal("t2", 1'b0, idx);
      check("t2 expect cand2", phase_sel, 2);
      for (int i = 0; i < 4; i++) c_rnd[i] = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         check("t2 track even", data_even, h_f0[edge_n - 1]);
         check("t2 track odd", data_odd, h_r0[edge_n]);
      end

      // Candidates 0 and 3 both clean: tie resolves to 0
      c_rnd = '{0, 0, 0, 0};
      c_val = '{PE, PO, PO, PE};
      run_cal("t3", 1'b0, idx);
      check("t3 tie low idx", phase_sel, 0);

      // One near-miss candidate with sporadic corruption, others random: fail
      setup_match($urandom_range(0, 3));
      corrupt_div = 32;
      run_cal("t4", 1'b1, idx);
      corrupt_div = 0;
      check("t4 cal_fail", cal_fail, 1);
      check("t4 valid low", data_valid, 0);

      // Reset during MEASURE of candidate 2
      setup_match(0);
      tick();
      cal_start = 1'b1;
      s = edge_n + 1;
      tick();
      cal_start = 1'b0;
      target = s + 2 * SLOT + SETTLE + 100;
      while (edge_n < target) tick();
      check("t5 measuring cand2", phase_sel, 2);
      check("t5 busy before reset", cal_busy, 1);
      #1 rst_n = 1'b0;
      #1;
      check("t5 async reset outputs",
            {data_even, data_odd, data_valid, phase_sel, best_err, cal_busy, cal_done, cal_fail}, 0);
      repeat (4) tick();
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (cal_done) pulses++;
      end
      check("t5 no done after reset", pulses, 0);
      check("t5 idle after reset", cal_busy, 0);

      // Lock on candidate 0, then retrain with only candidate 3 matching
      setup_match(0);
      run_cal("t6a", 1'b0, idx);
      check("t6a expect cand0", phase_sel, 0);
      setup_match(3);
      run_cal("t6b", 1'b0, idx);
      check("t6b expect cand3", phase_sel, 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
